// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues held requests to instruction memory and
// buffers up to two returned instructions for the control unit.
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_drop_addr;
    logic [1:0]         r_count;
    logic [1:0]         w_count_next;
    logic [INSTR_W-1:0] r_q_instr [0:1];
    logic [ADDR_W-1:0]  r_q_pc    [0:1];

    logic               w_push;
    logic               w_pop;
    logic               w_wr_idx;
    logic               w_valid;

    assign w_valid = (r_count != 2'd0);

    // Redirect cancels both queue movement and any data returned this cycle.
    assign w_push = (r_state == REQ) && imem_ack && !redirect;
    assign w_pop  = w_valid && !stall && !redirect;

    // Slot for the incoming word, accounting for the head shifting out.
    assign w_wr_idx = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);

    always_comb begin
        w_count_next = r_count;
        if (redirect) begin
            w_count_next = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 2'd1;
                2'b01:   w_count_next = r_count - 2'd1;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        imem_addr    = '0;
        case (r_state)
            IDLE: begin
                if (redirect || (w_count_next != 2'd2)) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = r_pc;
                if (redirect) begin
                    w_state_next = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    w_state_next = (w_count_next == 2'd2) ? IDLE : REQ;
                end
            end
            DROP: begin
                // The stale request must still complete before refetching.
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
                if (imem_ack) begin
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_drop_addr <= '0;
            r_count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (redirect) begin
                r_pc <= redirect_addr;
                if ((r_state == REQ) && !imem_ack) begin
                    r_drop_addr <= r_pc;
                end
            end else if (w_push) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_pop) begin
                r_q_instr[0] <= r_q_instr[1];
                r_q_pc[0]    <= r_q_pc[1];
            end
            if (w_push) begin
                r_q_instr[w_wr_idx] <= imem_rdata;
                r_q_pc[w_wr_idx]    <= r_pc;
            end
        end
    end

    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_q_instr[0] : '0;
    assign pc_out      = w_valid ? r_q_pc[0] : '0;
    assign opcode      = instr[INSTR_W-1 -: 4];

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined processor. It keeps the program counter, issues level-held requests to instruction memory, and buffers up to two returned instructions in a small queue. It presents the head instruction and its 4-bit opcode (`instr[15:12]`) to the control unit every cycle. It takes PC redirects from BEQ/JMP resolution and a stall from downstream; when the queue is empty it presents NOP (0000).

## Interface
- `ADDR_W`, default 8, width of PC and instruction-memory address.
- `INSTR_W`, default 16, instruction width; opcode is bits `[INSTR_W-1:INSTR_W-4]`.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  request to instruction memory, held high until `imem_ack`.
- `imem_addr`  out  ADDR_W  request address, stable while `imem_req` is high.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; may arrive in the same cycle as `imem_req`.
- `imem_rdata`  in  INSTR_W  instruction word, valid when `imem_ack` is high.
- `stall`  in  1  downstream cannot take the head instruction this cycle.
- `redirect`  in  1  branch/jump taken; flush and refetch.
- `redirect_addr`  in  ADDR_W  new PC when `redirect` is high.
- `instr`  out  INSTR_W  head of queue, or 0 when the queue is empty.
- `opcode`  out  4  top 4 bits of `instr`; feeds the control unit.
- `pc_out`  out  ADDR_W  address of the head instruction, or 0 when the queue is empty.
- `instr_valid`  out  1  queue non-empty.

## Operation
- Registers:
  - `pc`: next fetch address.
  - Queue: 2 entries, each holding instr and its pc; `count` is 0..2.
  - `drop_addr`.
  - FSM state: IDLE, REQ or DROP.
- IDLE:
  - `imem_req`=0.
  - Go to REQ when the post-edge count < 2.
- REQ:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`: push {`imem_rdata`, `pc`} and set `pc <= pc+1`, wrapping modulo 2^ADDR_W.
  - Next state is REQ if the post-edge count < 2, else IDLE.
- DROP:
  - `imem_req`=1, `imem_addr`=`drop_addr`, so the outstanding request is never abandoned.
  - On `imem_ack`: discard the data and go to REQ.
- Pop: occurs when `instr_valid && !stall`, and removes the head at the edge. Push and pop may occur in the same cycle, leaving count unchanged.
- Redirect has priority over push, pop and stall. At the edge:
  - count <= 0 and `pc <= redirect_addr`.
  - If in REQ without `imem_ack`: `drop_addr <= pc`, go to DROP.
  - If in REQ with `imem_ack` the same cycle: discard the data, go to REQ.
  - If in DROP without `imem_ack`: stay in DROP with `drop_addr` unchanged.
  - If in DROP with `imem_ack`: go to REQ.
  - If in IDLE: go to REQ.
- Empty queue: `instr`=0, `opcode`=0000 (NOP), `pc_out`=0, `instr_valid`=0.
- `stall` with an empty queue has no effect.
- Count never exceeds 2. A push when count==2 cannot occur, because no request is made while full.

## Timing
- Reset (async, immediate) sets:
  - State IDLE, `pc`=0, count=0, `drop_addr`=0.
  - Outputs `imem_req`=0, `imem_addr`=0, `instr`=0, `opcode`=0, `pc_out`=0, `instr_valid`=0.
- First edge after `rst` falls: IDLE → REQ. `imem_req` rises in cycle 1.
- Zero-wait memory (ack in the request cycle): instruction appears on `instr` one edge after the ack. The first valid instruction is in cycle 2 after reset release; sustained throughput is 1 per cycle.
- N wait cycles: `imem_req`/`imem_addr` are held for N+1 cycles.
- Redirect: `instr_valid`=0 from the next cycle.
  - Zero-wait memory: the target instruction is valid 2 cycles after the redirect edge.
  - In DROP: add the cycles remaining until the stale ack.
- Outputs are registered or decoded from registers only. No combinational path from `imem_rdata` to `instr`; from `stall` to `imem_req` is permitted only via next state, not combinationally.
- Reset mid-request or mid-DROP: return to reset values immediately. No ack is awaited, and the memory must tolerate a dropped request.

## Test plan
- Reset, zero-wait memory with `mem[a]=a|0x1000`: `imem_req`=1 in cycle 1; `instr`=0x1000, `pc_out`=0 in cycle 2; then 0x1001, 0x1002 in successive cycles.
- Memory acks 3 cycles after request: `imem_addr`=0 is held 4 cycles; `instr_valid` pulses once per 4 cycles; `opcode` is 0000 in between.
- `stall`=1 for 6 cycles with zero-wait memory: count reaches 2, `imem_req` drops to 0, head stays at `pc_out`=0. On release: outputs 0, 1, 2… with no gap or duplicate.
- Redirect to 0x40 while a request to 0x05 waits 2 more cycles: FSM enters DROP with `imem_addr`=0x05 held. Its data never appears. Next request is to 0x40, and `pc_out`=0x40 is the first valid instruction after.
- Redirect to 0xFF with zero-wait memory: outputs `pc_out` 0xFF, 0x00, 0x01 (wrap).
- Assert `rst` while count==2 and a request is outstanding: in the same cycle, `instr_valid`=0, `imem_req`=0, `opcode`=0. After release, fetch restarts at 0.
